// File: rtl/nbit_sub_pkg.sv
// Shared types and one-bit borrow arithmetic for the bit-serial subtractor.
package nbit_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } sub_state_t;

    function automatic logic sub_diff(input logic a, input logic b, input logic bin);
        return a ^ b ^ bin;
    endfunction

    // Borrow is generated when a=0,b=1, or propagated when a==b.
    function automatic logic sub_borrow(input logic a, input logic b, input logic bin);
        return (~a & b) | (~(a ^ b) & bin);
    endfunction

endpackage

// File: rtl/nbit_serial_subtractor_fullsub.sv
// One-bit combinational full-subtractor cell: d = a - b - bin, bout = borrow out.
module Fullsubtractor
    import nbit_sub_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = sub_diff(a, b, bin);
    assign bout = sub_borrow(a, b, bin);

endmodule

// File: rtl/nbit_serial_subtractor.sv
// Bit-serial N-bit subtractor F = A - B - borrowin, LSB first, one bit per clock.
// Optional signed-overflow output is built when SIGNED_OVF_EN is defined.
module nbit_serial_subtractor
    import nbit_sub_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         borrowin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] F,
    output logic         borrowout
`ifdef SIGNED_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    sub_state_t    r_state;
    sub_state_t    w_state_next;

    logic [N-1:0]  r_a_sr;
    logic [N-1:0]  r_b_sr;
    logic [N-1:0]  r_f;
    logic          r_bor;
    logic          r_borrowout;
    logic [CW-1:0] r_cnt;

    logic          w_load;
    logic          w_shift;
    logic          w_last;
    logic          w_d;
    logic          w_bout;

    assign in_ready  = (r_state == ST_IDLE) | ((r_state == ST_DONE) & out_ready);
    assign out_valid = (r_state == ST_DONE);
    assign F         = r_f;
    assign borrowout = r_borrowout;

    assign w_load  = in_valid & in_ready;
    assign w_shift = (r_state == ST_SHIFT);
    assign w_last  = w_shift & (r_cnt == CW'(N - 1));

    Fullsubtractor u_fullsub (
        .a    (r_a_sr[0]),
        .b    (r_b_sr[0]),
        .bin  (r_bor),
        .d    (w_d),
        .bout (w_bout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                // A new request taken in the same cycle as the result keeps the pipe bubble-free.
                if (out_ready) begin
                    w_state_next = in_valid ? ST_SHIFT : ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sr      <= '0;
            r_b_sr      <= '0;
            r_f         <= '0;
            r_bor       <= 1'b0;
            r_borrowout <= 1'b0;
            r_cnt       <= '0;
        end else if (w_load) begin
            r_a_sr <= A;
            r_b_sr <= B;
            r_bor  <= borrowin;
            r_cnt  <= '0;
        end else if (w_shift) begin
            r_a_sr <= {1'b0, r_a_sr[N-1:1]};
            r_b_sr <= {1'b0, r_b_sr[N-1:1]};
            r_f    <= {w_d, r_f[N-1:1]};
            r_bor  <= w_bout;
            // Counter stops at N-1 so it never wraps inside an operation.
            if (w_last) begin
                r_borrowout <= w_bout;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

`ifdef SIGNED_OVF_EN
    logic r_sa;
    logic r_sb;
    logic r_ovf;

    assign ovf = r_ovf;

    // The last difference bit produced is the result sign, so overflow resolves with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sa  <= 1'b0;
            r_sb  <= 1'b0;
            r_ovf <= 1'b0;
        end else if (w_load) begin
            r_sa <= A[N-1];
            r_sb <= B[N-1];
        end else if (w_last) begin
            r_ovf <= (r_sa != r_sb) & (w_d != r_sa);
        end
    end
`endif

endmodule

// File: tb/tb_nbit_serial_subtractor.sv
// Scoreboard bench for nbit_serial_subtractor (N=8); ovf checks active with SIGNED_OVF_EN.
module tb_nbit_serial_subtractor;

    localparam int N = 8;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         borrowin;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] F;
    logic         borrowout;
    logic         ovf;

    typedef struct {
        logic [N-1:0] f;
        logic         bo;
        logic         ov;
        int           acc;
    } exp_t;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         bin;
        logic [N-1:0] f;
        logic         bo;
        logic         ov;
    } vec_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   seen = 0;

    nbit_serial_subtractor #(.N(N)) dut (
`ifdef SIGNED_OVF_EN
        .ovf       (ovf),
`endif
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .borrowin  (borrowin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .F         (F),
        .borrowout (borrowout)
    );

`ifndef SIGNED_OVF_EN
    assign ovf = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Monitor: pops one expected result per output handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            seen = 0;
        end else if (out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_result", 32'(out_valid), 32'd0);
            end else begin
                if (!seen) begin
                    seen = 1;
                    chk("latency_cycle", 32'(cyc), 32'(q[0].acc + N));
                end
                if (out_ready) begin
                    e = q.pop_front();
                    $display("RESULT F=0x%02h borrowout=%0b ovf=%0b (expect 0x%02h %0b %0b)",
                             F, borrowout, ovf, e.f, e.bo, e.ov);
                    chk("F", 32'(F), 32'(e.f));
                    chk("borrowout", 32'(borrowout), 32'(e.bo));
`ifdef SIGNED_OVF_EN
                    chk("ovf", 32'(ovf), 32'(e.ov));
`endif
                    seen = 0;
                end
            end
        end
    end

    // Called at posedge+1; presents the request and returns at posedge+1 after acceptance.
    task automatic issue(input vec_t v, output int waits);
        exp_t e;
        bit   done;
        done     = 0;
        waits    = 0;
        in_valid = 1'b1;
        A        = v.a;
        B        = v.b;
        borrowin = v.bin;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                e.f = v.f; e.bo = v.bo; e.ov = v.ov; e.acc = cyc + 1;
                q.push_back(e);
                $display("ISSUE A=0x%02h B=0x%02h bin=%0b", v.a, v.b, v.bin);
                done = 1;
            end else begin
                waits++;
            end
        end
        if (!done) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
        chk("drain", 32'(q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[5];
    vec_t v;
    int   waits;
    bit   saw;

    initial begin
        vecs[0] = '{a: 8'h05, b: 8'h03, bin: 1'b0, f: 8'h02, bo: 1'b0, ov: 1'b0};
        vecs[1] = '{a: 8'h00, b: 8'h01, bin: 1'b0, f: 8'hFF, bo: 1'b1, ov: 1'b0};
        vecs[2] = '{a: 8'h10, b: 8'h0F, bin: 1'b1, f: 8'h00, bo: 1'b0, ov: 1'b0};
        vecs[3] = '{a: 8'h07, b: 8'h07, bin: 1'b0, f: 8'h00, bo: 1'b0, ov: 1'b0};
        vecs[4] = '{a: 8'h00, b: 8'h00, bin: 1'b1, f: 8'hFF, bo: 1'b1, ov: 1'b0};

        rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; borrowin = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_F", 32'(F), 32'd0);
        chk("reset_borrowout", 32'(borrowout), 32'd0);
        chk("reset_ovf", 32'(ovf), 32'd0);
        @(posedge clk);
        #1;

        // Directed vectors with immediate consumption.
        for (int i = 0; i < 5; i++) begin
            issue(vecs[i], waits);
            drain();
        end

        // Backpressure: result held for five cycles, then back-to-back reload.
        out_ready = 1'b0;
        v = '{a: 8'h40, b: 8'h0A, bin: 1'b0, f: 8'h36, bo: 1'b0, ov: 1'b0};
        issue(v, waits);
        for (int i = 0; i < 30 && !out_valid; i++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_F", 32'(F), 32'h36);
            chk("hold_borrowout", 32'(borrowout), 32'd0);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        v = '{a: 8'h20, b: 8'h01, bin: 1'b0, f: 8'h1F, bo: 1'b0, ov: 1'b0};
        issue(v, waits);
        chk("b2b_same_cycle_accept", 32'(waits), 32'd0);
        @(negedge clk);
        chk("b2b_no_bubble_valid", 32'(out_valid), 32'd0);
        drain();

        // Reset during the third SHIFT cycle aborts the operation.
        v = '{a: 8'h33, b: 8'h11, bin: 1'b0, f: 8'h22, bo: 1'b0, ov: 1'b0};
        issue(v, waits);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        q.delete();
        @(posedge clk);
        @(negedge clk);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_F", 32'(F), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        saw = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) saw = 1;
        end
        chk("abort_no_stale_result", 32'(saw), 32'd0);
        @(posedge clk);
        #1;

`ifdef SIGNED_OVF_EN
        v = '{a: 8'h80, b: 8'h01, bin: 1'b0, f: 8'h7F, bo: 1'b0, ov: 1'b1};
        issue(v, waits);
        drain();
        v = '{a: 8'h7F, b: 8'hFF, bin: 1'b0, f: 8'h80, bo: 1'b1, ov: 1'b1};
        issue(v, waits);
        drain();
        v = '{a: 8'h05, b: 8'h03, bin: 1'b0, f: 8'h02, bo: 1'b0, ov: 1'b0};
        issue(v, waits);
        drain();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
